pulse_event_arbiter: RTL and testbench

//  Collects single-cycle synchronized pulses from a bank of trailing-edge retimers and serializes them.

---
 rtl/pulse_event_arbiter_pkg.sv | 14 +
 rtl/pulse_event_arbiter_if.sv | 21 ++
 rtl/pulse_event_arbiter_rr_priority_pick.sv | 35 +++
 rtl/pulse_event_arbiter.sv | 128 ++++++++++++
 tb/tb_pulse_event_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_event_arbiter_pkg.sv
// rtl/pulse_event_arbiter_pkg.sv - shared types and constants for the pulse event arbiter
package pulse_event_arbiter_pkg;

  // Arbiter FSM: waiting for work, presenting an event, enforced idle gap
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  // Holdoff counter width; covers Holdoff values 0..255
  localparam int HOLD_W = 8;

endpackage

// File: rtl/pulse_event_arbiter_if.sv
// rtl/pulse_event_arbiter_if.sv - valid/ready event channel between arbiter and consumer
interface pulse_event_arbiter_if #(
  parameter int Id_Width = 2
);
  logic                Event_Valid;
  logic                Event_Ready;
  logic [Id_Width-1:0] Event_Id;

  // Arbiter side drives the event, consumer side returns ready
  modport master (
    output Event_Valid,
    output Event_Id,
    input  Event_Ready
  );

  modport slave (
    input  Event_Valid,
    input  Event_Id,
    output Event_Ready
  );
endinterface

// File: rtl/pulse_event_arbiter_rr_priority_pick.sv
// rtl/pulse_event_arbiter_rr_priority_pick.sv - round-robin first-set-bit search from a start pointer
module rr_priority_pick #(
  parameter int Width    = 4,
  parameter int Id_Width = 2
) (
  input  logic [Width-1:0]    req,
  input  logic [Id_Width-1:0] start,
  output logic                found,
  output logic [Id_Width-1:0] index
);

  logic [2*Width-1:0]  dbl;
  logic [Width-1:0]    rot;
  logic [Id_Width-1:0] off;
  logic [Id_Width:0]   sum;

  // Rotate the request vector so start lands at bit 0, take the lowest set bit, then undo the rotation
  always_comb begin
    dbl   = {req, req} >> start;
    rot   = dbl[Width-1:0];
    found = |rot;
    off   = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = Id_Width'(i);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (Id_Width + 1)'(Width)) begin
      sum = sum - (Id_Width + 1)'(Width);
    end
    index = sum[Id_Width-1:0];
  end

endmodule

// File: rtl/pulse_event_arbiter.sv
// rtl/pulse_event_arbiter.sv - latches per-channel pulses and serializes them round-robin over valid/ready
module pulse_event_arbiter
  import pulse_event_arbiter_pkg::*;
#(
  parameter int Width    = 4,
  parameter int Id_Width = 2,
  parameter int Holdoff  = 0
) (
  input  logic                 clk,
  input  logic                 ares_L,
  input  logic [Width-1:0]     Pulse_In,
  input  logic [Width-1:0]     Ovf_Clear,
  output logic [Width-1:0]     Pending,
  output logic [Width-1:0]     Overflow,
  pulse_event_arbiter_if.master evt
);

  localparam logic [HOLD_W-1:0]   HOLD_V   = HOLD_W'(Holdoff);
  localparam logic [Id_Width-1:0] LAST_IDX = Id_Width'(Width - 1);

  arb_state_t          state, state_nxt;
  logic                valid_q, valid_nxt;
  logic [Id_Width-1:0] id_q, id_nxt;
  logic [Id_Width-1:0] ptr, ptr_nxt;
  logic [HOLD_W-1:0]   cnt, cnt_nxt;
  logic                accept;
  logic [Width-1:0]    acc_vec;
  logic [Width-1:0]    pend_nxt, ovf_nxt;
  logic                pick_found;
  logic [Id_Width-1:0] pick_idx;

  assign accept          = valid_q & evt.Event_Ready;
  assign evt.Event_Valid = valid_q;
  assign evt.Event_Id    = id_q;

  rr_priority_pick #(
    .Width   (Width),
    .Id_Width(Id_Width)
  ) u_pick (
    .req  (Pending),
    .start(ptr),
    .found(pick_found),
    .index(pick_idx)
  );

  // One-hot of the channel being accepted this cycle
  always_comb begin
    acc_vec = '0;
    if (accept) begin
      acc_vec[id_q] = 1'b1;
    end
  end

  // A new pulse always re-arms Pending; overflow only when the old request is not leaving, set beats clear
  always_comb begin
    pend_nxt = Pulse_In | (Pending & ~acc_vec);
    ovf_nxt  = (Pulse_In & Pending & ~acc_vec) | (Overflow & ~Ovf_Clear);
  end

  // Request and sticky overflow registers
  always_ff @(posedge clk or negedge ares_L) begin
    if (!ares_L) begin
      Pending  <= '0;
      Overflow <= '0;
    end else begin
      Pending  <= pend_nxt;
      Overflow <= ovf_nxt;
    end
  end

  // Next state: arbitrate only from IDLE, hold the presented event until it is taken, then optional gap
  always_comb begin
    state_nxt = state;
    valid_nxt = valid_q;
    id_nxt    = id_q;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          id_nxt    = pick_idx;
          valid_nxt = 1'b1;
          state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (accept) begin
          valid_nxt = 1'b0;
          ptr_nxt   = (id_q == LAST_IDX) ? '0 : id_q + 1'b1;
          if (Holdoff > 0) begin
            state_nxt = ST_GAP;
            cnt_nxt   = HOLD_V;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt_nxt == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // FSM, presented event, round-robin pointer and gap counter registers
  always_ff @(posedge clk or negedge ares_L) begin
    if (!ares_L) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      valid_q <= valid_nxt;
      id_q    <= id_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// tb/tb_pulse_event_arbiter.sv - randomized and directed bench against an event-level reference model
module tb_pulse_event_arbiter;

  localparam int W  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          ares_L;
  logic [W-1:0]  pulse;
  logic [W-1:0]  clr;
  logic          ready;

  logic          dv  [2];
  logic [IW-1:0] did [2];
  logic [W-1:0]  dp  [2];
  logic [W-1:0]  dov [2];

  always #5 clk = ~clk;

  pulse_event_arbiter_if #(.Id_Width(IW)) if0 ();
  pulse_event_arbiter_if #(.Id_Width(IW)) if3 ();

  assign if0.Event_Ready = ready;
  assign if3.Event_Ready = ready;
  assign dv[0]  = if0.Event_Valid;
  assign did[0] = if0.Event_Id;
  assign dv[1]  = if3.Event_Valid;
  assign did[1] = if3.Event_Id;

  pulse_event_arbiter #(.Width(W), .Id_Width(IW), .Holdoff(0)) dut0 (
    .clk      (clk),
    .ares_L   (ares_L),
    .Pulse_In (pulse),
    .Ovf_Clear(clr),
    .Pending  (dp[0]),
    .Overflow (dov[0]),
    .evt      (if0.master)
  );

  pulse_event_arbiter #(.Width(W), .Id_Width(IW), .Holdoff(3)) dut3 (
    .clk      (clk),
    .ares_L   (ares_L),
    .Pulse_In (pulse),
    .Ovf_Clear(clr),
    .Pending  (dp[1]),
    .Overflow (dov[1]),
    .evt      (if3.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one record per DUT, event level
  logic [W-1:0] m_pend [2];
  logic [W-1:0] m_ovf  [2];
  bit           m_valid[2];
  int           m_id   [2];
  int           m_ptr  [2];
  int           m_gap  [2];

  function automatic int hold_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d]  = '0;
      m_ovf[d]   = '0;
      m_valid[d] = 1'b0;
      m_id[d]    = 0;
      m_ptr[d]   = 0;
      m_gap[d]   = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic [W-1:0] np;
      logic [W-1:0] no;
      bit           acc;
      bit           taken;
      bit           got;
      acc = m_valid[d] && ready;
      np  = m_pend[d];
      no  = m_ovf[d] & ~clr;
      for (int i = 0; i < W; i++) begin
        taken = acc && (m_id[d] == i);
        if (pulse[i] && m_pend[d][i] && !taken) no[i] = 1'b1;
        if (taken) np[i] = 1'b0;
        if (pulse[i]) np[i] = 1'b1;
      end
      if (m_valid[d]) begin
        if (acc) begin
          m_valid[d] = 1'b0;
          m_ptr[d]   = (m_id[d] + 1) % W;
          m_gap[d]   = hold_of(d);
        end
      end else if (m_gap[d] > 0) begin
        m_gap[d]--;
      end else begin
        got = 1'b0;
        for (int k = 0; k < W; k++) begin
          if (!got && m_pend[d][(m_ptr[d] + k) % W]) begin
            got        = 1'b1;
            m_valid[d] = 1'b1;
            m_id[d]    = (m_ptr[d] + k) % W;
          end
        end
      end
      m_pend[d] = np;
      m_ovf[d]  = no;
    end
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_valid", d), 32'(dv[d]), 32'(m_valid[d]));
      check($sformatf("d%0d_id", d), 32'(did[d]), 32'(m_id[d]));
      check($sformatf("d%0d_pending", d), 32'(dp[d]), 32'(m_pend[d]));
      check($sformatf("d%0d_overflow", d), 32'(dov[d]), 32'(m_ovf[d]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!ares_L) model_reset();
    else model_step();
    #1;
    compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    ares_L = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    ares_L = 1'b1;
  endtask

  task automatic wait_valid(input int d, input int budget, input string tag);
    bit seen;
    seen = dv[d];
    for (int n = 0; n < budget && !seen; n++) begin
      step();
      seen = dv[d];
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  int got_ids[$];
  int first_t[2];
  int second_t[2];

  initial begin
    ares_L = 1'b0;
    pulse  = '0;
    clr    = '0;
    ready  = 1'b1;
    model_reset();
    #12;
    compare();
    @(negedge clk);
    ares_L = 1'b1;

    // T1: single pulse on ch2
    pulse = 4'b0100;
    step();
    pulse = '0;
    check("t1_pending", 32'(dp[0]), 32'h4);
    step();
    check("t1_valid", 32'(dv[0]), 32'd1);
    check("t1_id", 32'(did[0]), 32'd2);
    step();
    check("t1_pending_clr", 32'(dp[0]), 32'h0);
    check("t1_valid_clr", 32'(dv[0]), 32'd0);
    repeat (6) step();

    // T2: round-robin order from a fresh pointer, then wrap
    do_reset();
    pulse = 4'b1111;
    step();
    pulse = '0;
    got_ids.delete();
    repeat (8) begin
      step();
      if (dv[0]) got_ids.push_back(int'(did[0]));
    end
    check("t2_count", 32'(got_ids.size()), 32'd4);
    for (int i = 0; i < got_ids.size(); i++) check($sformatf("t2_id%0d", i), 32'(got_ids[i]), 32'(i));
    repeat (12) step();
    pulse = 4'b0011;
    step();
    pulse = '0;
    got_ids.delete();
    repeat (6) begin
      step();
      if (dv[0]) got_ids.push_back(int'(did[0]));
    end
    check("t2_wrap_count", 32'(got_ids.size()), 32'd2);
    for (int i = 0; i < got_ids.size(); i++) check($sformatf("t2_wrap_id%0d", i), 32'(got_ids[i]), 32'(i));
    repeat (10) step();

    // T3: backpressure holds Id=1 while ch3 queues behind it
    ready = 1'b0;
    pulse = 4'b0010;
    step();
    pulse = '0;
    wait_valid(0, 6, "t3_wait");
    check("t3_id", 32'(did[0]), 32'd1);
    pulse = 4'b1000;
    step();
    pulse = '0;
    repeat (9) begin
      step();
      check("t3_hold_id", 32'(did[0]), 32'd1);
    end
    ready = 1'b1;
    step();
    wait_valid(0, 6, "t3_next_wait");
    check("t3_next_id", 32'(did[0]), 32'd3);
    check("t3_overflow", 32'(dov[0]), 32'd0);
    repeat (12) step();

    // T4: overflow set, set-beats-clear, lone clear
    ready = 1'b0;
    pulse = 4'b0001;
    step();
    pulse = '0;
    step();
    step();
    pulse = 4'b0001;
    step();
    pulse = '0;
    check("t4_ovf", 32'(dov[0]), 32'h1);
    step();
    check("t4_ovf_sticky", 32'(dov[0]), 32'h1);
    clr   = 4'b0001;
    pulse = 4'b0001;
    step();
    clr   = '0;
    pulse = '0;
    check("t4_set_wins", 32'(dov[0][0]), 32'd1);
    clr = 4'b0001;
    step();
    clr = '0;
    check("t4_cleared", 32'(dov[0]), 32'h0);
    ready = 1'b1;
    repeat (12) step();

    // T5: pulse on ch2 in the same cycle ch2 is accepted
    ready = 1'b0;
    pulse = 4'b0100;
    step();
    pulse = '0;
    wait_valid(0, 6, "t5_wait");
    check("t5_id", 32'(did[0]), 32'd2);
    ready = 1'b1;
    pulse = 4'b0100;
    step();
    pulse = '0;
    check("t5_pending_kept", 32'(dp[0][2]), 32'd1);
    check("t5_no_ovf", 32'(dov[0][2]), 32'd0);
    wait_valid(0, 4, "t5_re_wait");
    check("t5_re_id", 32'(did[0]), 32'd2);
    repeat (12) step();

    // T6a: spacing between back-to-back events is 2+Holdoff cycles
    do_reset();
    ready = 1'b1;
    pulse = 4'b0011;
    step();
    pulse = '0;
    first_t  = '{-1, -1};
    second_t = '{-1, -1};
    for (int n = 0; n < 20; n++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        if (dv[d]) begin
          if (first_t[d] < 0) first_t[d] = n;
          else if (second_t[d] < 0) second_t[d] = n;
        end
      end
    end
    check("t6_spacing_h0", 32'(second_t[0] - first_t[0]), 32'd2);
    check("t6_spacing_h3", 32'(second_t[1] - first_t[1]), 32'd5);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      pulse = W'($urandom) & W'($urandom);
      ready = ($urandom_range(9, 0) < 7);
      clr   = ($urandom_range(7, 0) == 0) ? W'($urandom) : '0;
      step();
    end
    pulse = '0;
    clr   = '0;

    // T6b: reset while an event is presented drops it for good
    ready = 1'b0;
    pulse = 4'b0001;
    step();
    pulse = '0;
    wait_valid(1, 20, "t6_wait_h3");
    wait_valid(0, 20, "t6_wait_h0");
    #2;
    ares_L = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t6_rst_valid%0d", d), 32'(dv[d]), 32'd0);
      check($sformatf("t6_rst_id%0d", d), 32'(did[d]), 32'd0);
      check($sformatf("t6_rst_pend%0d", d), 32'(dp[d]), 32'd0);
      check($sformatf("t6_rst_ovf%0d", d), 32'(dov[d]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    ares_L = 1'b1;
    ready  = 1'b1;
    repeat (8) begin
      step();
      check("t6_no_replay", 32'(dv[0] | dv[1]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
